// File: rtl/seq_div_pkg.sv
// Shared types and sizing helpers for the iterative restoring divider.
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int unsigned DIV_W_DEFAULT = 32;

    // Step counter width: enough to hold WIDTH-1, never less than one bit.
    function automatic int unsigned div_cnt_w(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted_c;

    // Compare is one bit wider than the operands, so the partial remainder never overflows.
    always_comb begin
        shifted_c = {rem_i, bit_i};
        q_bit_o   = (shifted_c >= {1'b0, divisor_i});
        rem_o     = q_bit_o ? WIDTH'(shifted_c - {1'b0, divisor_i}) : shifted_c[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
// Optional macro DIV_ZERO_CHECK_EN: short-circuit divide-by-zero straight to DONE and flag it.
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = div_cnt_w(WIDTH);

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept_c;
    logic             step_qbit_c;
    logic [WIDTH-1:0] step_rem_c;
`ifdef DIV_ZERO_CHECK_EN
    logic             dbz_q, dbz_d;
`endif

    // The quotient register doubles as the dividend shift register; its MSB feeds each step.
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .bit_i     (quot_q[WIDTH-1]),
        .divisor_i (dsr_q),
        .rem_o     (step_rem_c),
        .q_bit_o   (step_qbit_c)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
`ifdef DIV_ZERO_CHECK_EN
                    state_d = (divisor == '0) ? DONE : BUSY;
`else
                    state_d = BUSY;
`endif
                end
            end
            BUSY:    if (cnt_q == '0) state_d = DONE;
            DONE:    if (out_ready)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = (state_q == DONE);
        accept_c  = in_valid && in_ready;
    end

    always_comb begin
        quot_d = quot_q;
        rem_d  = rem_q;
        dsr_d  = dsr_q;
        cnt_d  = cnt_q;
`ifdef DIV_ZERO_CHECK_EN
        dbz_d  = dbz_q;
`endif
        if (state_q == IDLE && accept_c) begin
            quot_d = dividend;
            rem_d  = '0;
            dsr_d  = divisor;
            cnt_d  = CNT_W'(WIDTH - 1);
`ifdef DIV_ZERO_CHECK_EN
            dbz_d  = (divisor == '0);
            if (divisor == '0) begin
                quot_d = '1;
                rem_d  = dividend;
            end
`endif
        end else if (state_q == BUSY) begin
            quot_d = {quot_q[WIDTH-2:0], step_qbit_c};
            rem_d  = step_rem_c;
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quot_q <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
`ifdef DIV_ZERO_CHECK_EN
            dbz_q  <= 1'b0;
`endif
        end else begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dsr_q  <= dsr_d;
            cnt_q  <= cnt_d;
`ifdef DIV_ZERO_CHECK_EN
            dbz_q  <= dbz_d;
`endif
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;
`ifdef DIV_ZERO_CHECK_EN
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases, backpressure, reset abort, random regression.
module tb_seq_divider;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one operation once the divider is ready and queue its reference result.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("issue_ready", W'(in_ready), W'(1));
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
`ifdef DIV_ZERO_CHECK_EN
        e.dbz = (b == '0);
        e.lat = (b == '0) ? 1 : W + 1;
`else
        e.dbz = 1'b0;
        e.lat = W + 1;
`endif
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // Wait for the result, compare against the scoreboard, optionally stall and inject junk.
    task automatic collect(input int hold, input bit junk);
        exp_t e;
        int   n = 0;
        while (!out_valid && n < W + 10) begin
            if (junk) begin
                in_valid = 1'b1;
                dividend = $urandom;
                divisor  = $urandom;
            end
            @(posedge clk); #1; n++;
        end
        e = sb.pop_front();
        chk("latency", W'(n + 1), W'(e.lat));
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", W'(div_by_zero), W'(e.dbz));
        for (int i = 0; i < hold; i++) begin
            if (junk) begin
                in_valid = 1'b1;
                dividend = $urandom;
                divisor  = $urandom;
            end
            @(posedge clk); #1;
            chk("hold_valid", W'(out_valid), W'(1));
            chk("hold_ready", W'(in_ready), W'(0));
            chk("hold_q", quotient, e.q);
            chk("hold_r", remainder, e.r);
            chk("hold_dbz", W'(div_by_zero), W'(e.dbz));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_valid", W'(out_valid), W'(0));
        chk("release_ready", W'(in_ready), W'(1));
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", W'(in_ready), W'(0));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_q", quotient, '0);
        chk("rst_r", remainder, '0);
        chk("rst_dbz", W'(div_by_zero), W'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_in_ready", W'(in_ready), W'(1));

        issue(W'(100), W'(7));           collect(0, 1'b0);
        issue('1, W'(1));                collect(0, 1'b0);
        issue(W'(5), W'(9));             collect(0, 1'b0);
        issue(W'(9), W'(9));             collect(0, 1'b0);
        issue(W'(1234), '0);             collect(0, 1'b0);
        issue(W'(32'hFFFF_FFFF), W'(32'h8000_0001)); collect(0, 1'b0);
        issue(W'(77777), W'(123));       collect(5, 1'b0);
        issue(W'(987654321), W'(1000));  collect(5, 1'b1);

        // Abort a 1000/3 mid-flight; the in-flight result must vanish.
        issue(W'(1000), W'(3));
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_in_ready", W'(in_ready), W'(0));
        chk("abort_out_valid", W'(out_valid), W'(0));
        chk("abort_q", quotient, '0);
        chk("abort_r", remainder, '0);
        rst = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        chk("after_abort_ready", W'(in_ready), W'(1));
        chk("after_abort_valid", W'(out_valid), W'(0));
        issue(W'(1000), W'(3));          collect(0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 49) == 0) b = '0;
            issue(a, b);
            collect(0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
